// File: rtl/zcd_pkg.sv
// Shared types and defaults for the ZCD frame controller.
package zcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HUNT    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_PARITY  = 2'd3
    } zcd_frame_state_t;

    localparam logic [3:0] ZCD_PREAMBLE     = 4'b0101;
    localparam int         ZCD_PAYLOAD_BITS = 8;
    localparam int         ZCD_TIMEOUT_CYC  = 64;

endpackage

// File: rtl/zcd_frame_ctrl_if.sv
// Frame output handshake between the frame controller and its consumer.
// valid/ready: a frame transfers on every cycle where frame_valid and
// frame_ready are both high; frame_data holds steady while frame_valid is
// high, and frame_valid never drops without a completed transfer.
interface zcd_frame_ctrl_if
    import zcd_pkg::*;
#(
    parameter int PAYLOAD_BITS = ZCD_PAYLOAD_BITS
);
    logic [PAYLOAD_BITS-1:0] frame_data;
    logic                    frame_valid;
    logic                    frame_ready;

    modport master (output frame_data, output frame_valid, input frame_ready);
    modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/zcd_preamble_match.sv
// 4-bit sliding preamble window. The hit output compares the stored window
// extended by the incoming bit, so the caller sees the match in the same
// cycle the completing bit arrives.
module zcd_preamble_match
    import zcd_pkg::*;
#(
    parameter logic [3:0] PATTERN = ZCD_PREAMBLE
) (
    input  logic clk,
    input  logic rst,
    input  logic shift,
    input  logic clear,
    input  logic bit_in,
    output logic hit
);
    logic [3:0] window;
    logic [3:0] window_next;

    assign window_next = {window[2:0], bit_in};
    assign hit         = shift && !clear && (window_next == PATTERN);

    // Window register: clear wins over shift, new bit enters the LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window <= 4'd0;
        end else if (clear) begin
            window <= 4'd0;
        end else if (shift) begin
            window <= window_next;
        end
    end
endmodule

// File: rtl/zcd_frame_ctrl.sv
// Frame controller for the pulse-interval decoder: hunts for a preamble,
// collects payload plus even parity, and hands the frame to a consumer.
module zcd_frame_ctrl
    import zcd_pkg::*;
#(
    parameter int         PAYLOAD_BITS = ZCD_PAYLOAD_BITS,
    parameter int         TIMEOUT_CYC  = ZCD_TIMEOUT_CYC,
    parameter logic [3:0] PREAMBLE     = ZCD_PREAMBLE
) (
    input  logic             sclk_3mhz,
    input  logic             reset,
    input  logic             enable,
    input  logic             bit_valid,
    input  logic             bit_value,
    input  logic             bit_err,
    output logic             decode_en,
    output logic             busy,
    output logic             parity_err,
    output logic             timeout_err,
    output logic             overrun_err,
    output zcd_frame_state_t state,
    zcd_frame_ctrl_if.master frame
);
    localparam int CNT_W  = $clog2(PAYLOAD_BITS + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(PAYLOAD_BITS - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC - 1);

    zcd_frame_state_t        state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [IDLE_W-1:0]       idle_cnt_q, idle_cnt_d;
    logic [PAYLOAD_BITS-1:0] payload_q, payload_d;
    logic                    pre_shift, pre_clear, pre_hit;
    logic                    parity_d, timeout_d, overrun_d, frame_load;
    logic                    parity_ok, timed_out;

    zcd_preamble_match #(.PATTERN(PREAMBLE)) u_match (
        .clk    (sclk_3mhz),
        .rst    (reset),
        .shift  (pre_shift),
        .clear  (pre_clear),
        .bit_in (bit_value),
        .hit    (pre_hit)
    );

    assign parity_ok = ~((^payload_q) ^ bit_value);
    assign timed_out = (idle_cnt_q == IDLE_MAX) && !bit_valid;
    assign state     = state_q;

    // Next-state, counter and pulse decode; enable low overrides everything.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        idle_cnt_d = idle_cnt_q;
        payload_d  = payload_q;
        pre_shift  = 1'b0;
        pre_clear  = 1'b0;
        parity_d   = 1'b0;
        timeout_d  = 1'b0;
        overrun_d  = 1'b0;
        frame_load = 1'b0;
        if (!enable) begin
            state_d    = ST_IDLE;
            pre_clear  = 1'b1;
            bit_cnt_d  = '0;
            idle_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pre_clear = 1'b1;
                    state_d   = ST_HUNT;
                end
                ST_HUNT: begin
                    if (bit_err) begin
                        pre_clear = 1'b1;
                    end else if (bit_valid) begin
                        pre_shift = 1'b1;
                        if (pre_hit) begin
                            state_d    = ST_PAYLOAD;
                            bit_cnt_d  = '0;
                            idle_cnt_d = '0;
                        end
                    end
                end
                ST_PAYLOAD, ST_PARITY: begin
                    if (bit_err) begin
                        state_d    = ST_HUNT;
                        pre_clear  = 1'b1;
                        idle_cnt_d = '0;
                    end else if (bit_valid) begin
                        idle_cnt_d = '0;
                        if (state_q == ST_PAYLOAD) begin
                            payload_d = PAYLOAD_BITS'({payload_q, bit_value});
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            if (bit_cnt_q == LAST_BIT) state_d = ST_PARITY;
                        end else begin
                            state_d   = ST_HUNT;
                            pre_clear = 1'b1;
                            if (!parity_ok) begin
                                parity_d = 1'b1;
                            end else if (!frame.frame_valid || frame.frame_ready) begin
                                frame_load = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end
                    end else if (timed_out) begin
                        timeout_d  = 1'b1;
                        state_d    = ST_HUNT;
                        pre_clear  = 1'b1;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge sclk_3mhz or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Counters, payload, output stage and registered status/pulse outputs.
    always_ff @(posedge sclk_3mhz or posedge reset) begin
        if (reset) begin
            bit_cnt_q         <= '0;
            idle_cnt_q        <= '0;
            payload_q         <= '0;
            frame.frame_data  <= '0;
            frame.frame_valid <= 1'b0;
            decode_en         <= 1'b0;
            busy              <= 1'b0;
            parity_err        <= 1'b0;
            timeout_err       <= 1'b0;
            overrun_err       <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            payload_q   <= payload_d;
            decode_en   <= (state_d != ST_IDLE);
            busy        <= (state_d == ST_PAYLOAD) || (state_d == ST_PARITY);
            parity_err  <= parity_d;
            timeout_err <= timeout_d;
            overrun_err <= overrun_d;
            if (frame_load) begin
                frame.frame_data  <= payload_q;
                frame.frame_valid <= 1'b1;
            end else if (frame.frame_valid && frame.frame_ready) begin
                frame.frame_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_zcd_frame_ctrl.sv
// Directed bench for zcd_frame_ctrl (PAYLOAD_BITS=8, TIMEOUT_CYC=64).
module tb_zcd_frame_ctrl;
    import zcd_pkg::*;

    logic             sclk_3mhz;
    logic             reset;
    logic             enable;
    logic             bit_valid;
    logic             bit_value;
    logic             bit_err;
    logic             decode_en;
    logic             busy;
    logic             parity_err;
    logic             timeout_err;
    logic             overrun_err;
    zcd_frame_state_t dut_state;

    int tests = 0;
    int fails = 0;

    zcd_frame_ctrl_if #(.PAYLOAD_BITS(8)) fif ();

    zcd_frame_ctrl #(.PAYLOAD_BITS(8), .TIMEOUT_CYC(64), .PREAMBLE(4'b0101)) dut (
        .sclk_3mhz   (sclk_3mhz),
        .reset       (reset),
        .enable      (enable),
        .bit_valid   (bit_valid),
        .bit_value   (bit_value),
        .bit_err     (bit_err),
        .decode_en   (decode_en),
        .busy        (busy),
        .parity_err  (parity_err),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err),
        .state       (dut_state),
        .frame       (fif)
    );

    // Clock generation.
    initial sclk_3mhz = 1'b0;
    always #5 sclk_3mhz = ~sclk_3mhz;

    task automatic tick();
        @(posedge sclk_3mhz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_value = b;
        tick();
        bit_valid = 1'b0;
        bit_value = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic check_no_pulses(input string tag);
        check({tag, "_parity_err"}, 32'(parity_err), 32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        check({tag, "_overrun_err"}, 32'(overrun_err), 32'd0);
    endtask

    initial begin
        reset           = 1'b1;
        enable          = 1'b0;
        bit_valid       = 1'b0;
        bit_value       = 1'b0;
        bit_err         = 1'b0;
        fif.frame_ready = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_state", 32'(dut_state), 32'(ST_IDLE));
        check("rst_decode_en", 32'(decode_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_valid", 32'(fif.frame_valid), 32'd0);
        check("rst_frame_data", 32'(fif.frame_data), 32'd0);
        check_no_pulses("rst");
        reset = 1'b0;
        tick();
        check("idle_hold", 32'(decode_en), 32'd0);

        // Good frame 0xB2, parity 0
        fif.frame_ready = 1'b1;
        enable = 1'b1;
        tick();
        check("en_decode_en", 32'(decode_en), 32'd1);
        check("en_state", 32'(dut_state), 32'(ST_HUNT));
        send_bits(16'b010, 3);
        check("good_busy_pre3", 32'(busy), 32'd0);
        send_bit(1'b1);
        check("good_busy_match", 32'(busy), 32'd1);
        send_bits(16'hB2, 8);
        check("good_state_parity", 32'(dut_state), 32'(ST_PARITY));
        send_bit(1'b0);
        check("good_valid", 32'(fif.frame_valid), 32'd1);
        check("good_data", 32'(fif.frame_data), 32'hB2);
        check("good_busy_done", 32'(busy), 32'd0);
        check_no_pulses("good");
        tick();
        check("good_valid_consumed", 32'(fif.frame_valid), 32'd0);

        // Overlapping preamble: match at the 4th bit, bits 5-6 start the payload
        send_bits(16'b0101_01, 6);
        send_bits(16'b101011, 6);
        send_bit(1'b1);
        check("ovl_valid", 32'(fif.frame_valid), 32'd1);
        check("ovl_data", 32'(fif.frame_data), 32'h6B);
        check_no_pulses("ovl");
        tick();

        // Overrun: two frames with ready low
        fif.frame_ready = 1'b0;
        send_bits(16'b0101, 4);
        send_bits(16'hC3, 8);
        send_bit(1'b0);
        check("ovr_first_valid", 32'(fif.frame_valid), 32'd1);
        check("ovr_first_data", 32'(fif.frame_data), 32'hC3);
        send_bits(16'b0101, 4);
        send_bits(16'h0F, 8);
        send_bit(1'b0);
        check("ovr_pulse", 32'(overrun_err), 32'd1);
        check("ovr_data_kept", 32'(fif.frame_data), 32'hC3);
        check("ovr_valid_kept", 32'(fif.frame_valid), 32'd1);
        tick();
        check("ovr_pulse_end", 32'(overrun_err), 32'd0);
        fif.frame_ready = 1'b1;
        tick();
        check("ovr_drain", 32'(fif.frame_valid), 32'd0);

        // Bad parity then a clean frame
        send_bits(16'b0101, 4);
        send_bits(16'h01, 8);
        send_bit(1'b0);
        check("par_pulse", 32'(parity_err), 32'd1);
        check("par_no_frame", 32'(fif.frame_valid), 32'd0);
        check("par_state", 32'(dut_state), 32'(ST_HUNT));
        tick();
        check("par_pulse_end", 32'(parity_err), 32'd0);
        send_bits(16'b0101, 4);
        send_bits(16'h5A, 8);
        send_bit(1'b0);
        check("par_next_valid", 32'(fif.frame_valid), 32'd1);
        check("par_next_data", 32'(fif.frame_data), 32'h5A);
        tick();

        // Timeout after 3 payload bits
        send_bits(16'b0101, 4);
        send_bits(16'b101, 3);
        for (int i = 0; i < 63; i++) begin
            tick();
            check("to_quiet", 32'(timeout_err), 32'd0);
        end
        check("to_busy_before", 32'(busy), 32'd1);
        tick();
        check("to_pulse", 32'(timeout_err), 32'd1);
        check("to_busy_after", 32'(busy), 32'd0);
        tick();
        check("to_pulse_end", 32'(timeout_err), 32'd0);
        send_bits(16'b11, 2);
        send_bits(16'b0101, 4);
        send_bits(16'h3C, 8);
        send_bit(1'b0);
        check("to_next_valid", 32'(fif.frame_valid), 32'd1);
        check("to_next_data", 32'(fif.frame_data), 32'h3C);
        tick();

        // Decoder error with a coincident bit on payload bit 5
        send_bits(16'b0101, 4);
        send_bits(16'b1010, 4);
        bit_err = 1'b1;
        send_bit(1'b1);
        bit_err = 1'b0;
        check("err_state", 32'(dut_state), 32'(ST_HUNT));
        check("err_busy", 32'(busy), 32'd0);
        check_no_pulses("err");
        send_bits(16'b1111, 4);
        check("err_no_frame", 32'(fif.frame_valid), 32'd0);
        check_no_pulses("err_tail");

        // Enable dropped mid-payload
        send_bits(16'b0101, 4);
        send_bits(16'b110, 3);
        enable = 1'b0;
        tick();
        check("dis_decode_en", 32'(decode_en), 32'd0);
        check("dis_state", 32'(dut_state), 32'(ST_IDLE));
        check("dis_busy", 32'(busy), 32'd0);
        send_bits(16'b0101, 4);
        check("dis_ignored", 32'(dut_state), 32'(ST_IDLE));
        check("dis_no_frame", 32'(fif.frame_valid), 32'd0);

        // Re-enable, hold a frame, then drop enable and assert async reset
        enable = 1'b1;
        fif.frame_ready = 1'b0;
        tick();
        send_bits(16'b0101, 4);
        send_bits(16'h81, 8);
        send_bit(1'b0);
        check("hold_valid", 32'(fif.frame_valid), 32'd1);
        check("hold_data", 32'(fif.frame_data), 32'h81);
        enable = 1'b0;
        tick();
        check("hold_after_dis_valid", 32'(fif.frame_valid), 32'd1);
        check("hold_after_dis_data", 32'(fif.frame_data), 32'h81);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(fif.frame_valid), 32'd0);
        check("arst_data", 32'(fif.frame_data), 32'd0);
        check("arst_decode_en", 32'(decode_en), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_state", 32'(dut_state), 32'(ST_IDLE));
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
